// File: rtl/rd_ptr_empty_ctrl.sv
// Read-side pointer and empty control for an asynchronous FIFO: write-pointer
// synchronizer, binary/Gray read pointer, empty, level, almost-empty and sticky underflow.
module rd_ptr_empty_ctrl #(
  parameter int unsigned addr_width   = 4,
  parameter int unsigned sync_stages  = 2,
  parameter int unsigned ae_threshold = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [addr_width:0]   wr_ptr_grey_coded,
  input  logic                  r_inc,
  output logic [addr_width:0]   rd_ptr_grey_coded,
  output logic [addr_width-1:0] r_address,
  output logic                  empty_flag,
  output logic                  almost_empty_flag,
  output logic [addr_width:0]   rd_level,
  output logic                  underflow_err
);

  localparam logic [addr_width:0] AE_LVL = ae_threshold[addr_width:0];

  logic [addr_width:0] wr_sync [sync_stages];
  logic [addr_width:0] wr_gray_sync;
  logic [addr_width:0] wr_bin_sync;
  logic [addr_width:0] rd_ptr;
  logic [addr_width:0] rd_ptr_nxt;
  logic                rd_accept;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      for (int unsigned i = 0; i < sync_stages; i++) wr_sync[i] <= '0;
    end else begin
      wr_sync[0] <= wr_ptr_grey_coded;
      for (int unsigned i = 1; i < sync_stages; i++) wr_sync[i] <= wr_sync[i-1];
    end
  end

  assign wr_gray_sync = wr_sync[sync_stages-1];

  always_comb begin
    wr_bin_sync             = '0;
    wr_bin_sync[addr_width] = wr_gray_sync[addr_width];
    for (int unsigned i = addr_width; i > 0; i--)
      wr_bin_sync[i-1] = wr_bin_sync[i] ^ wr_gray_sync[i-1];
  end

  assign empty_flag        = (rd_ptr_grey_coded == wr_gray_sync);
  assign rd_level          = wr_bin_sync - rd_ptr;
  assign almost_empty_flag = (rd_level <= AE_LVL);
  assign r_address         = rd_ptr[addr_width-1:0];
  assign rd_accept         = r_inc & ~empty_flag;
  assign rd_ptr_nxt        = rd_ptr + 1'b1;

  // Gray pointer is registered from the incremented binary so the write domain never sees glitches.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rd_ptr            <= '0;
      rd_ptr_grey_coded <= '0;
      underflow_err     <= 1'b0;
    end else begin
      if (rd_accept) begin
        rd_ptr            <= rd_ptr_nxt;
        rd_ptr_grey_coded <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
      end
      if (r_inc && empty_flag) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Bench for rd_ptr_empty_ctrl: an occupancy-level model checked every cycle plus
// hand-computed literal checkpoints along a directed sequence.
module tb_rd_ptr_empty_ctrl;
  localparam int AW = 4;
  localparam int SS = 2;
  localparam int AE = 2;
  localparam int N  = 1 << (AW + 1);

  logic          r_clk = 1'b0;
  logic          r_rst;
  logic          r_inc;
  logic [AW:0]   wr_b;
  logic [AW:0]   wr_ptr_grey_coded;
  logic [AW:0]   rd_ptr_grey_coded;
  logic [AW:0]   rd_level;
  logic [AW-1:0] r_address;
  logic          empty_flag, almost_empty_flag, underflow_err;

  int tests = 0;
  int fails = 0;

  assign wr_ptr_grey_coded = wr_b ^ (wr_b >> 1);

  rd_ptr_empty_ctrl #(.addr_width(AW), .sync_stages(SS), .ae_threshold(AE)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .wr_ptr_grey_coded(wr_ptr_grey_coded), .r_inc(r_inc),
    .rd_ptr_grey_coded(rd_ptr_grey_coded), .r_address(r_address), .empty_flag(empty_flag),
    .almost_empty_flag(almost_empty_flag), .rd_level(rd_level), .underflow_err(underflow_err)
  );

  always #5 r_clk = ~r_clk;

  // Model: read count, write value seen SS edges late, sticky underflow.
  int m_rd = 0;
  int m_pipe [SS];
  bit m_uf = 1'b0;
  bit live = 1'b0;

  function automatic int m_level();
    return (((m_pipe[SS-1] - m_rd) % N) + N) % N;
  endfunction

  always @(posedge r_clk) begin
    if (r_rst) begin
      m_rd <= 0;
      m_uf <= 1'b0;
      for (int i = 0; i < SS; i++) m_pipe[i] <= 0;
      live <= 1'b1;
    end else begin
      if (r_inc && m_level() == 0) m_uf <= 1'b1;
      if (r_inc && m_level() != 0) m_rd <= (m_rd + 1) % N;
      m_pipe[0] <= int'(wr_b);
      for (int i = 1; i < SS; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge r_clk) begin
    #1;
    if (live) begin
      chk("m_addr",  32'(r_address), 32'(m_rd % (N / 2)));
      chk("m_gray",  32'(rd_ptr_grey_coded), 32'(m_rd ^ (m_rd >> 1)));
      chk("m_level", 32'(rd_level), 32'(m_level()));
      chk("m_empty", 32'(empty_flag), 32'(m_level() == 0));
      chk("m_ae",    32'(almost_empty_flag), 32'(m_level() <= AE));
      chk("m_uf",    32'(underflow_err), 32'(m_uf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  initial begin
    r_rst = 1'b1; r_inc = 1'b1; wr_b = '0;
    tick(2);
    chk("rst_addr", 32'(r_address), 0);
    chk("rst_gray", 32'(rd_ptr_grey_coded), 0);
    chk("rst_empty", 32'(empty_flag), 1);
    chk("rst_level", 32'(rd_level), 0);
    chk("rst_ae", 32'(almost_empty_flag), 1);
    chk("rst_uf", 32'(underflow_err), 0);

    r_rst = 1'b0; r_inc = 1'b0; wr_b = 5'd3;
    tick(1);
    chk("sync1_empty", 32'(empty_flag), 1);
    tick(1);
    chk("sync2_empty", 32'(empty_flag), 0);
    chk("sync2_level", 32'(rd_level), 3);
    chk("sync2_ae", 32'(almost_empty_flag), 0);
    chk("model_level3", 32'(m_level()), 3);

    r_inc = 1'b1; tick(1); r_inc = 1'b0;
    chk("rd1_addr", 32'(r_address), 1);
    chk("rd1_gray", 32'(rd_ptr_grey_coded), 1);
    chk("rd1_level", 32'(rd_level), 2);
    chk("rd1_ae", 32'(almost_empty_flag), 1);

    r_inc = 1'b1; tick(2);
    tick(1); r_inc = 1'b0;
    chk("uf_set", 32'(underflow_err), 1);
    chk("uf_addr", 32'(r_address), 3);
    chk("uf_gray", 32'(rd_ptr_grey_coded), 2);
    chk("uf_empty", 32'(empty_flag), 1);
    tick(10);
    chk("uf_sticky", 32'(underflow_err), 1);

    wr_b = 5'd7; tick(2);
    r_inc = 1'b1; tick(4); r_inc = 1'b0;
    chk("mid_addr7", 32'(r_address), 7);
    chk("mid_uf", 32'(underflow_err), 1);
    r_rst = 1'b1; r_inc = 1'b1; tick(1);
    r_rst = 1'b0; r_inc = 1'b0;
    chk("mid_rst_addr", 32'(r_address), 0);
    chk("mid_rst_gray", 32'(rd_ptr_grey_coded), 0);
    chk("mid_rst_uf", 32'(underflow_err), 0);
    chk("mid_rst_empty", 32'(empty_flag), 1);
    chk("mid_rst_level", 32'(rd_level), 0);
    chk("mid_rst_ae", 32'(almost_empty_flag), 1);
    tick(1);
    chk("mid_sync1_empty", 32'(empty_flag), 1);
    tick(1);
    chk("mid_sync2_level", 32'(rd_level), 7);

    wr_b = 5'd17; tick(2);
    chk("wrap_pre_level", 32'(rd_level), 17);
    r_inc = 1'b1; tick(15); r_inc = 1'b0;
    chk("wrap_addr15", 32'(r_address), 15);
    chk("wrap_level2", 32'(rd_level), 2);
    r_inc = 1'b1; tick(1); r_inc = 1'b0;
    chk("wrap_addr0", 32'(r_address), 0);
    chk("wrap_gray", 32'(rd_ptr_grey_coded), 5'b11000);
    chk("wrap_level1", 32'(rd_level), 1);

    r_rst = 1'b1; wr_b = 5'd16; tick(1);
    r_rst = 1'b0; tick(2);
    chk("full_level", 32'(rd_level), 16);
    chk("full_empty", 32'(empty_flag), 0);
    chk("full_ae", 32'(almost_empty_flag), 0);
    chk("model_level16", 32'(m_level()), 16);
    r_inc = 1'b1; tick(1); r_inc = 1'b0;
    chk("full_rd_level", 32'(rd_level), 15);
    chk("full_rd_addr", 32'(r_address), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
